// File: rtl/alu_sequencer_if.sv
// Command and direct-load port bundle for alu_sequencer.
// The master drives commands and loads; the slave (the sequencer) returns cmd_ready.
interface alu_sequencer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_rd;
  logic [2:0]  cmd_rn;
  logic [2:0]  cmd_rm;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_rd,
    output cmd_rn,
    output cmd_rm,
    output ld_en,
    output ld_addr,
    output ld_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_rd,
    input  cmd_rn,
    input  cmd_rm,
    input  ld_en,
    input  ld_addr,
    input  ld_data,
    output cmd_ready
  );

endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle front end for an external combinational 16-bit ALU.
// It runs IDLE -> GETA -> GETB -> EXEC -> WRITE over an internal 8x16 register file.
module alu_sequencer (
  input  logic                  clk,
  input  logic                  reset_n,
  alu_sequencer_if.slave        cmd,
  output logic [15:0]           alu_a,
  output logic [15:0]           alu_b,
  output logic [1:0]            alu_op,
  input  logic [15:0]           alu_out,
  input  logic                  alu_z,
  output logic [15:0]           result,
  output logic                  status_z,
  output logic                  done
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StGetA  = 3'd1;
  localparam logic [2:0] StGetB  = 3'd2;
  localparam logic [2:0] StExec  = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  rd_q, rd_d;
  logic [2:0]  rn_q, rn_d;
  logic [2:0]  rm_q, rm_d;
  logic [15:0] result_q, result_d;
  logic        z_q, z_d;
  logic        accept;

  // A direct load owns the IDLE cycle, so a command is held off while ld_en is high.
  assign cmd.cmd_ready = (state_q == StIdle) && !cmd.ld_en;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  always_comb begin
    state_d  = state_q;
    regs_d   = regs_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rn_d     = rn_q;
    rm_d     = rm_q;
    result_d = result_q;
    z_d      = z_q;

    case (state_q)
      StIdle: begin
        if (cmd.ld_en) begin
          regs_d[cmd.ld_addr] = cmd.ld_data;
        end else if (accept) begin
          op_d    = cmd.cmd_op;
          rd_d    = cmd.cmd_rd;
          rn_d    = cmd.cmd_rn;
          rm_d    = cmd.cmd_rm;
          state_d = StGetA;
        end
      end
      StGetA: begin
        a_d     = regs_q[rn_q];
        state_d = StGetB;
      end
      StGetB: begin
        b_d     = regs_q[rm_q];
        state_d = StExec;
      end
      StExec: begin
        result_d = alu_out;
        z_d      = alu_z;
        state_d  = StWrite;
      end
      StWrite: begin
        regs_d[rd_q] = result_q;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      regs_q   <= regs_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rn_q     <= rn_d;
      rm_q     <= rm_d;
      result_q <= result_d;
      z_q      <= z_d;
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign result   = result_q;
  assign status_z = z_q;
  assign done     = (state_q == StWrite);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: table-driven ALU commands, scoreboarded results,
// and hand-written sequences for aliasing, load interplay and mid-command reset.
module tb_alu_sequencer;

  logic        clk;
  logic        reset_n;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_z;
  logic [15:0] result;
  logic        status_z;
  logic        done;

  alu_sequencer_if cmd_if ();

  alu_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd      (cmd_if.slave),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .alu_z    (alu_z),
    .result   (result),
    .status_z (status_z),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU the sequencer drives.
  always_comb begin
    alu_out = 16'h0000;
    case (alu_op)
      2'b00:   alu_out = alu_a + alu_b;
      2'b01:   alu_out = alu_a - alu_b;
      2'b10:   alu_out = alu_a & alu_b;
      default: alu_out = ~alu_b;
    endcase
    alu_z = (alu_out == 16'h0000);
  end

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] exp_res;
    logic        exp_z;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        z;
  } sb_t;

  vec_t        vecs [6];
  sb_t         sb [$];
  logic [15:0] model [8];
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [2:0] addr, input logic [15:0] data);
    cmd_if.ld_en   = 1'b1;
    cmd_if.ld_addr = addr;
    cmd_if.ld_data = data;
    @(posedge clk);
    @(negedge clk);
    cmd_if.ld_en = 1'b0;
    model[addr]  = data;
  endtask

  // Issues one command, checks handshake timing and EXEC operands, pops the scoreboard on done.
  task automatic issue_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rn,
                           input logic [2:0] rm, input logic [15:0] exp_res, input logic exp_z,
                           input bit ld_in_exec);
    logic [15:0] ea;
    logic [15:0] eb;
    sb_t         e;
    int          w;
    bit          seen;
    #1;
    w = 0;
    while (!cmd_if.cmd_ready && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!cmd_if.cmd_ready) begin
      check("ready_timeout", 32'(cmd_if.cmd_ready), 32'd1);
      return;
    end
    ea = model[rn];
    eb = model[rm];
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_rd    = rd;
    cmd_if.cmd_rn    = rn;
    cmd_if.cmd_rm    = rm;
    sb.push_back('{res: exp_res, z: exp_z});
    model[rd] = exp_res;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'($urandom);
    cmd_if.cmd_rd    = 3'($urandom);
    cmd_if.cmd_rn    = 3'($urandom);
    cmd_if.cmd_rm    = 3'($urandom);
    seen = 1'b0;
    for (int cyc = 1; cyc <= 8 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc <= 4) check("ready_busy", 32'(cmd_if.cmd_ready), 32'd0);
      if (cyc == 3) begin
        check("exec_alu_a", 32'(alu_a), 32'(ea));
        check("exec_alu_b", 32'(alu_b), 32'(eb));
        check("exec_alu_op", 32'(alu_op), 32'(op));
      end
      if (done) begin
        seen = 1'b1;
        check("done_cycle", 32'(cyc), 32'd4);
        if (sb.size() == 0) begin
          check("sb_empty", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          check("result", 32'(result), 32'(e.res));
          check("status_z", 32'(status_z), 32'(e.z));
        end
      end
      if (ld_in_exec && cyc == 3) begin
        cmd_if.ld_en   = 1'b1;
        cmd_if.ld_addr = 3'd6;
        cmd_if.ld_data = 16'hDEAD;
      end
      if (ld_in_exec && cyc == 4) cmd_if.ld_en = 1'b0;
    end
    if (!seen) check("done_timeout", 32'(seen), 32'd1);
    @(negedge clk);
    #1;
    check("ready_after", 32'(cmd_if.cmd_ready), 32'd1);
    check("done_idle", 32'(done), 32'd0);
  endtask

  // AND of a register with itself returns its value without changing it.
  task automatic readback(input logic [2:0] r);
    issue_cmd(2'b10, r, r, r, model[r], model[r] == 16'h0000, 1'b0);
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  initial begin
    int pulses;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;

    vecs[0] = '{op: 2'b00, rd: 3'd3, rn: 3'd1, rm: 3'd2, va: 16'h0007, vb: 16'h0003,
                exp_res: 16'h000A, exp_z: 1'b0};
    vecs[1] = '{op: 2'b01, rd: 3'd3, rn: 3'd1, rm: 3'd2, va: 16'h0005, vb: 16'h0005,
                exp_res: 16'h0000, exp_z: 1'b1};
    vecs[2] = '{op: 2'b01, rd: 3'd3, rn: 3'd1, rm: 3'd2, va: 16'h0000, vb: 16'h0001,
                exp_res: 16'hFFFF, exp_z: 1'b0};
    vecs[3] = '{op: 2'b10, rd: 3'd6, rn: 3'd4, rm: 3'd5, va: 16'hF0F0, vb: 16'h0FF0,
                exp_res: 16'h00F0, exp_z: 1'b0};
    vecs[4] = '{op: 2'b11, rd: 3'd7, rn: 3'd4, rm: 3'd5, va: 16'hF0F0, vb: 16'h0FF0,
                exp_res: 16'hF00F, exp_z: 1'b0};
    vecs[5] = '{op: 2'b00, rd: 3'd0, rn: 3'd1, rm: 3'd2, va: 16'hFFFF, vb: 16'h0002,
                exp_res: 16'h0001, exp_z: 1'b0};

    reset_n          = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_rd    = 3'd0;
    cmd_if.cmd_rn    = 3'd0;
    cmd_if.cmd_rm    = 3'd0;
    cmd_if.ld_en     = 1'b0;
    cmd_if.ld_addr   = 3'd0;
    cmd_if.ld_data   = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      do_load(vecs[i].rn, vecs[i].va);
      do_load(vecs[i].rm, vecs[i].vb);
      issue_cmd(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].exp_res,
                vecs[i].exp_z, 1'b0);
      readback(vecs[i].rd);
    end

    // Full aliasing, then an immediate repeat that must see the first write-back.
    do_load(3'd1, 16'h0002);
    issue_cmd(2'b00, 3'd1, 3'd1, 3'd1, 16'h0004, 1'b0, 1'b0);
    issue_cmd(2'b00, 3'd1, 3'd1, 3'd1, 16'h0008, 1'b0, 1'b0);
    readback(3'd1);

    // ld_en during EXEC is ignored.
    do_load(3'd6, 16'h5555);
    issue_cmd(2'b00, 3'd0, 3'd1, 3'd2, model[1] + model[2], (model[1] + model[2]) == 16'h0,
              1'b1);
    readback(3'd6);

    // Load and command together in IDLE: load wins, command is not taken.
    cmd_if.ld_en     = 1'b1;
    cmd_if.ld_addr   = 3'd5;
    cmd_if.ld_data   = 16'hBEEF;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_rd    = 3'd4;
    cmd_if.cmd_rn    = 3'd5;
    cmd_if.cmd_rm    = 3'd5;
    #1;
    check("ready_ld", 32'(cmd_if.cmd_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    cmd_if.ld_en     = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    model[5]         = 16'hBEEF;
    #1;
    check("ready_post_ld", 32'(cmd_if.cmd_ready), 32'd1);
    count_done(6, pulses);
    check("ld_no_cmd", 32'(pulses), 32'd0);
    readback(3'd5);
    readback(3'd4);

    // Reset during GETB discards the command.
    do_load(3'd1, 16'h0003);
    do_load(3'd2, 16'h0004);
    #1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_rd    = 3'd7;
    cmd_if.cmd_rn    = 3'd1;
    cmd_if.cmd_rm    = 3'd2;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_alu_a", 32'(alu_a), 32'd0);
    check("mid_rst_alu_b", 32'(alu_b), 32'd0);
    check("mid_rst_alu_op", 32'(alu_op), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_status_z", 32'(status_z), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    #1;
    check("mid_rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    count_done(6, pulses);
    check("mid_rst_no_done", 32'(pulses), 32'd0);
    for (int r = 0; r < 8; r++) readback(3'(r));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that drives a single combinational 16-bit ALU (add, subtract, AND, NOT-B; zero flag) from an internal 8×16 register file. It accepts one register-to-register command per valid/ready handshake and stages operands into A/B latches. It issues the operation, captures the result and zero flag, and writes the result back. It sits on the master side of the ALU's Ain/Bin/ALUop/out/Z interface and is the front end the datapath uses to run ALU instructions.

## Interface
Parameters:
- none (data width 16, 8 registers, 2-bit op: fixed)

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command this cycle
- cmd_op  input  2  00 add, 01 sub (Rn−Rm), 10 AND, 11 NOT Rm
- cmd_rd  input  3  destination register
- cmd_rn  input  3  first source register (A operand)
- cmd_rm  input  3  second source register (B operand)
- ld_en  input  1  direct register load strobe
- ld_addr  input  3  register to load
- ld_data  input  16  value to load
- alu_a  output  16  to ALU Ain
- alu_b  output  16  to ALU Bin
- alu_op  output  2  to ALU ALUop
- alu_out  input  16  from ALU out
- alu_z  input  1  from ALU Z
- result  output  16  last captured ALU result
- status_z  output  1  zero flag of last executed command
- done  output  1  one-cycle pulse: write-back occurred

## Operation
- States: IDLE, GETA, GETB, EXEC, WRITE.
- IDLE:
  - cmd_ready = 1 iff state == IDLE and ld_en == 0.
  - On cmd_valid && cmd_ready: latch op/rd/rn/rm and go to GETA.
- GETA: A ← R[rn]; go to GETB.
- GETB: B ← R[rm]; go to EXEC.
- EXEC:
  - alu_a/alu_b already show A/B; alu_op shows the latched op.
  - Capture result ← alu_out and status_z ← alu_z; go to WRITE.
- WRITE: R[rd] ← result; done = 1; go to IDLE.
- Operand reads: all commands read both Rn and Rm, including op 11, where A is don't-care to the ALU.
- alu_a, alu_b, alu_op: driven continuously from the A, B and op registers. They hold their last values while idle.
- Direct load: ld_en in IDLE writes R[ld_addr] ← ld_data at the clock edge. ld_en outside IDLE is ignored, with no write and no error. Load beats command in the same IDLE cycle, because cmd_ready is low.
- Aliasing:
  - rd may equal rn or rm.
  - Operands are latched before write-back, so each command sees pre-command values.
  - Back-to-back commands see the previous command's write-back.
- Arithmetic: performed only by the external ALU. Results are modulo 2^16 with no carry or overflow. status_z = 1 iff the captured result is 0x0000.

## Timing
- Command accepted at edge 0 (end of IDLE cycle):
  - GETA in cycle 1, GETB in cycle 2, EXEC in cycle 3, WRITE in cycle 4.
  - done is high during cycle 4.
  - cmd_ready is high again in cycle 5.
- Throughput: one command per 5 cycles.
- result and status_z update at the end of EXEC, so they are visible in WRITE (cycle 4) and held until the next EXEC.
- Register write-back becomes visible at the edge ending WRITE.
- done is high for exactly one cycle per command and is never high in IDLE.
- Reset (asserted at any time, including mid-command):
  - State goes to IDLE immediately; the in-flight command is discarded with no write-back and no done.
  - All registers R0–R7, A, B, latched op/rd/rn/rm, result and status_z reset to 0.
  - done and alu_a/alu_b/alu_op read 0.
  - cmd_ready is 1 once reset_n is high and ld_en is 0.
- cmd_* inputs are sampled only on the accepting edge. Later changes have no effect.

## Test plan
- Reset then idle: assert reset_n = 0 mid-run → all outputs 0, cmd_ready = 1 after release, and a readback command shows R0–R7 = 0.
- Add:
  - Load R1 = 0x0007 and R2 = 0x0003.
  - Command op 00, rd = 3, rn = 1, rm = 2.
  - Expect alu_a = 7 and alu_b = 3 in EXEC.
  - Expect done in cycle 4 after accept, result = 0x000A, status_z = 0, R3 = 0x000A.
- Sub to zero and wrap:
  - R1 = 5, R2 = 5, op 01 → result 0, status_z = 1.
  - Then R1 = 0, R2 = 1, op 01 → result 0xFFFF, status_z = 0.
- AND and NOT:
  - R4 = 0xF0F0, R5 = 0x0FF0, op 10 → 0x00F0.
  - op 11 with rm = 5 → 0xF00F.
- Aliasing and back-to-back:
  - R1 = 2; op 00, rd = rn = rm = 1 → R1 = 4.
  - Immediately repeat → R1 = 8.
  - cmd_ready is low cycles 1–4 of each command.
- Load interplay and mid-command reset:
  - ld_en with cmd_valid in IDLE → load happens, command not accepted.
  - ld_en during EXEC → no register change.
  - reset_n low during GETB → no done, destination register stays 0.
